// File: rtl/mem_bus_arbiter.sv
// Two-requester, one-target arbiter for the native valid/ready memory bus.
// Round-robin between m0 and m1. The grant is held for a whole transaction.
// A bus timeout forces completion when the target never answers.
module mem_bus_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic        timeout_err,
   input  logic        timeout_clr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_BUSY    = 2'b01,
      ST_RELEASE = 2'b10
   } state_t;

   state_t      state_r, state_s;
   logic        grant_r, grant_s;
   logic        last_grant_r, last_grant_s;
   logic [15:0] timer_r, timer_s;
   logic        timeout_err_r, timeout_err_s;
   logic        busy_s;
   logic        timeout_hit_s;
   logic        done_s;
   logic [31:0] resp_rdata_s;

   // Completion detection: target ack, or timer expiry without an ack in the same cycle.
   always_comb begin
      busy_s        = (state_r == ST_BUSY);
      timeout_hit_s = 1'b0;
      if (busy_s && (TIMEOUT_CYCLES != 16'd0) &&
          (timer_r == (TIMEOUT_CYCLES - 16'd1)) && !s_ready) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
      done_s       = busy_s && (s_ready || timeout_hit_s);
      resp_rdata_s = s_ready ? s_rdata : TIMEOUT_RDATA;
   end

   // Next-state logic: arbitration in IDLE, completion in BUSY, one idle cycle in RELEASE.
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      last_grant_s = last_grant_r;
      timer_s      = timer_r;
      case (state_r)
         ST_IDLE: begin
            if (m0_valid && m1_valid) begin
               grant_s = ~last_grant_r;
               timer_s = 16'd0;
               state_s = ST_BUSY;
            end else if (m0_valid) begin
               grant_s = 1'b0;
               timer_s = 16'd0;
               state_s = ST_BUSY;
            end else if (m1_valid) begin
               grant_s = 1'b1;
               timer_s = 16'd0;
               state_s = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (timer_r != 16'hFFFF) begin
               timer_s = timer_r + 16'd1;
            end else begin
               timer_s = timer_r;
            end
            if (done_s) begin
               last_grant_s = grant_r;
               state_s      = ST_RELEASE;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_RELEASE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Sticky timeout flag: a new timeout beats a simultaneous clear.
   always_comb begin
      if (timeout_hit_s) begin
         timeout_err_s = 1'b1;
      end else if (timeout_clr) begin
         timeout_err_s = 1'b0;
      end else begin
         timeout_err_s = timeout_err_r;
      end
   end

   // State register. m0 wins the first tie after reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         grant_r       <= 1'b0;
         last_grant_r  <= 1'b1;
         timer_r       <= 16'd0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         last_grant_r  <= last_grant_s;
         timer_r       <= timer_s;
         timeout_err_r <= timeout_err_s;
      end
   end

   // Bus muxing. The response path is a combinational pass-through, so ready lands in the ack cycle.
   always_comb begin
      s_valid  = busy_s;
      s_addr   = 32'h0;
      s_wdata  = 32'h0;
      s_wstrb  = 4'h0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = 32'h0;
      m1_rdata = 32'h0;
      if (busy_s) begin
         if (grant_r) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = done_s;
            m1_rdata = done_s ? resp_rdata_s : 32'h0;
         end else begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = done_s;
            m0_rdata = done_s ? resp_rdata_s : 32'h0;
         end
      end else begin
         s_valid = 1'b0;
      end
      timeout_err = timeout_err_r;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (timeout shortened to 8 cycles).
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

   localparam logic [31:0] TO_RDATA = 32'hDEADBEEF;

   logic        clk;
   logic        resetn;
   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        timeout_err, timeout_clr;

   int n_vec = 0;
   int n_err = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(16'd8), .TIMEOUT_RDATA(TO_RDATA)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .timeout_err(timeout_err), .timeout_clr(timeout_clr)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      s_ready = 1'b0; s_rdata = 32'h0; timeout_clr = 1'b0;
   endtask

   task automatic pulse_reset;
      resetn = 1'b0;
      next_cyc();
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'h3;
      s_ready = 1'b1; s_rdata = $urandom; timeout_clr = 1'b0;
      next_cyc();
      next_cyc();
      @(negedge clk);
      n_vec++; if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b exp 0000", {s_valid, m0_ready, m1_ready, timeout_err}); end
      n_vec++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin n_err++; $display("FAIL reset_bus: got %h exp 0", {s_addr, s_wdata, s_wstrb}); end
      n_vec++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0", {m0_rdata, m1_rdata}); end
      next_cyc();
      idle_inputs();
      resetn = 1'b1;
   endtask

   task automatic test_single_read;
      m0_valid = 1'b1; m0_addr = 32'h1000_0040; m0_wdata = $urandom; m0_wstrb = 4'h0;
      @(negedge clk);
      n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rd_req_cycle s_valid: got %b exp 0", s_valid); end
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         if (i == 2) begin s_ready = 1'b1; s_rdata = 32'h12345678; end
         @(negedge clk);
         n_vec++; if ({s_valid, s_addr} !== {1'b1, 32'h1000_0040}) begin n_err++; $display("FAIL rd_busy%0d bus: got %h exp %h", i, {s_valid, s_addr}, {1'b1, 32'h1000_0040}); end
         n_vec++; if ({m0_ready, m0_rdata} !== {(i == 2), ((i == 2) ? 32'h12345678 : 32'h0)}) begin n_err++; $display("FAIL rd_busy%0d m0: got %h", i, {m0_ready, m0_rdata}); end
         n_vec++; if ({m1_ready, m1_rdata} !== 33'h0) begin n_err++; $display("FAIL rd_busy%0d m1: got %h exp 0", i, {m1_ready, m1_rdata}); end
      end
      next_cyc();
      m0_valid = 1'b0; s_ready = 1'b0; s_rdata = $urandom;
      @(negedge clk);
      n_vec++; if ({s_valid, m0_ready, m0_rdata} !== 34'h0) begin n_err++; $display("FAIL rd_release: got %h exp 0", {s_valid, m0_ready, m0_rdata}); end
      next_cyc();
   endtask

   task automatic test_round_robin;
      logic [31:0] r;
      pulse_reset();
      m0_valid = 1'b1; m0_addr = 32'h0000_1000;
      m1_valid = 1'b1; m1_addr = 32'h0000_2000;
      s_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rr%0d idle s_valid: got %b exp 0", k, s_valid); end
         next_cyc();
         r = $urandom; s_rdata = r;
         @(negedge clk);
         n_vec++; if (s_addr !== ((k % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000)) begin n_err++; $display("FAIL rr%0d order: got %h", k, s_addr); end
         n_vec++; if ({m0_ready, m1_ready} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr%0d ready: got %b", k, {m0_ready, m1_ready}); end
         n_vec++; if (((k % 2 == 1) ? m1_rdata : m0_rdata) !== r) begin n_err++; $display("FAIL rr%0d rdata: got %h exp %h", k, ((k % 2 == 1) ? m1_rdata : m0_rdata), r); end
         next_cyc();
         @(negedge clk);
         n_vec++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin n_err++; $display("FAIL rr%0d release: got %b exp 000", k, {s_valid, m0_ready, m1_ready}); end
         next_cyc();
      end
      idle_inputs();
   endtask

   task automatic test_m1_write;
      logic [31:0] r;
      m1_valid = 1'b1; m1_addr = 32'h0200_0010; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'b0011;
      @(negedge clk);
      n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL wr_req s_valid: got %b exp 0", s_valid); end
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         r = $urandom;
         s_ready = (i == 1); s_rdata = r;
         @(negedge clk);
         n_vec++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h0200_0010, 32'hA5A5A5A5, 4'b0011}) begin n_err++; $display("FAIL wr_busy%0d mirror: got %h", i, {s_valid, s_addr, s_wdata, s_wstrb}); end
         n_vec++; if ({m1_ready, m1_rdata, m0_ready} !== {(i == 1), ((i == 1) ? r : 32'h0), 1'b0}) begin n_err++; $display("FAIL wr_busy%0d ready: got %h", i, {m1_ready, m1_rdata, m0_ready}); end
      end
      next_cyc();
      m1_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      n_vec++; if ({s_valid, m1_ready} !== 2'b00) begin n_err++; $display("FAIL wr_release: got %b exp 00", {s_valid, m1_ready}); end
      next_cyc();
      idle_inputs();
   endtask

   task automatic test_timeout;
      m0_valid = 1'b1; m0_addr = 32'h3000_0000; m0_wstrb = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         next_cyc();
         s_ready = 1'b0; s_rdata = $urandom;
         timeout_clr = (i == 8);
         @(negedge clk);
         n_vec++; if ({m0_ready, m0_rdata} !== {(i == 8), ((i == 8) ? TO_RDATA : 32'h0)}) begin n_err++; $display("FAIL to_busy%0d m0: got %h", i, {m0_ready, m0_rdata}); end
         n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_busy%0d err: got %b exp 0", i, timeout_err); end
      end
      next_cyc();
      m0_valid = 1'b0; timeout_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++; if ({timeout_err, s_valid} !== 2'b10) begin n_err++; $display("FAIL to_sticky%0d: got %b exp 10", i, {timeout_err, s_valid}); end
         next_cyc();
      end
      timeout_clr = 1'b1;
      next_cyc();
      timeout_clr = 1'b0;
      @(negedge clk);
      n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b exp 0", timeout_err); end
      next_cyc();
   endtask

   task automatic test_timeout_tie;
      m0_valid = 1'b1; m0_addr = 32'h3000_0004;
      for (int i = 1; i <= 8; i++) begin
         next_cyc();
         s_ready = (i == 8); s_rdata = 32'hCAFE_0001;
         @(negedge clk);
         n_vec++; if ({m0_ready, m0_rdata} !== {(i == 8), ((i == 8) ? 32'hCAFE_0001 : 32'h0)}) begin n_err++; $display("FAIL tie_busy%0d m0: got %h", i, {m0_ready, m0_rdata}); end
      end
      next_cyc();
      m0_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tie_err: got %b exp 0", timeout_err); end
      next_cyc();
   endtask

   task automatic test_reset_mid_busy;
      m1_valid = 1'b1; m1_addr = 32'h4000_0100; m1_wstrb = 4'hF; m1_wdata = 32'h0BAD_F00D;
      next_cyc();
      @(negedge clk);
      n_vec++; if ({s_valid, s_addr} !== {1'b1, 32'h4000_0100}) begin n_err++; $display("FAIL rst_pre busy: got %h", {s_valid, s_addr}); end
      next_cyc();
      resetn = 1'b0;
      #1;
      n_vec++; if ({s_valid, m0_ready, m1_ready, s_addr, s_wdata, s_wstrb, m1_rdata} !== 103'h0) begin n_err++; $display("FAIL rst_mid outputs: got %h exp 0", {s_valid, m0_ready, m1_ready, s_addr, s_wdata, s_wstrb}); end
      next_cyc();
      resetn = 1'b1;
      @(negedge clk);
      n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rst_post idle: got %b exp 0", s_valid); end
      next_cyc();
      s_ready = 1'b1; s_rdata = 32'h7777_0001;
      @(negedge clk);
      n_vec++; if ({s_valid, s_addr, m1_ready, m1_rdata} !== {1'b1, 32'h4000_0100, 1'b1, 32'h7777_0001}) begin n_err++; $display("FAIL rst_post m1 grant: got %h", {s_valid, s_addr, m1_ready, m1_rdata}); end
      next_cyc();
      m0_valid = 1'b1; m0_addr = 32'h4000_0200;
      next_cyc();
      next_cyc();
      @(negedge clk);
      n_vec++; if ({s_addr, m0_ready, m1_ready} !== {32'h4000_0200, 1'b1, 1'b0}) begin n_err++; $display("FAIL rst_post tie: got %h", {s_addr, m0_ready, m1_ready}); end
      next_cyc();
      idle_inputs();
      next_cyc();
   endtask

   task automatic test_random;
      bit          v[2];
      logic [31:0] a[2], d[2];
      logic [3:0]  st[2];
      int          resume_at[2];
      int          owner, ow, busy_start, done_at, free_at, w, winner;
      bit          timed, last, err_m, busy, fin;
      logic [68:0] exp_bus;
      logic [32:0] exp_m0, exp_m1;
      idle_inputs();
      pulse_reset();
      v[0] = 1'b0; v[1] = 1'b0; resume_at[0] = 0; resume_at[1] = 0;
      a[0] = 32'h0; a[1] = 32'h0; d[0] = 32'h0; d[1] = 32'h0; st[0] = 4'h0; st[1] = 4'h0;
      owner = -1; busy_start = -10; done_at = -10; free_at = 0; w = 0;
      timed = 1'b0; last = 1'b1; err_m = 1'b0;
      for (int t = 0; t < 800; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!v[i] && t >= resume_at[i]) begin
               v[i] = 1'b1; a[i] = $urandom; d[i] = $urandom; st[i] = 4'($urandom_range(0, 15));
            end
         end
         m0_valid = v[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = st[0];
         m1_valid = v[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = st[1];
         busy = (owner >= 0) && (t >= busy_start) && (t <= done_at);
         fin  = busy && (t == done_at);
         ow   = (owner < 0) ? 0 : owner;
         s_ready = busy ? (t == busy_start + w) : ($urandom_range(0, 1) == 1);
         s_rdata = $urandom;
         timeout_clr = ($urandom_range(0, 7) == 0);
         winner = -1;
         if (!busy && t >= free_at && (v[0] || v[1])) begin
            winner = (v[0] && v[1]) ? (last ? 0 : 1) : (v[0] ? 0 : 1);
         end
         exp_bus = busy ? {1'b1, a[ow], d[ow], st[ow]} : 69'h0;
         exp_m0  = (fin && ow == 0) ? {1'b1, (timed ? TO_RDATA : s_rdata)} : 33'h0;
         exp_m1  = (fin && ow == 1) ? {1'b1, (timed ? TO_RDATA : s_rdata)} : 33'h0;
         @(negedge clk);
         n_vec++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== exp_bus) begin n_err++; $display("FAIL rand_bus t=%0d: got %h exp %h", t, {s_valid, s_addr, s_wdata, s_wstrb}, exp_bus); end
         n_vec++; if ({m0_ready, m0_rdata} !== exp_m0) begin n_err++; $display("FAIL rand_m0 t=%0d: got %h exp %h", t, {m0_ready, m0_rdata}, exp_m0); end
         n_vec++; if ({m1_ready, m1_rdata} !== exp_m1) begin n_err++; $display("FAIL rand_m1 t=%0d: got %h exp %h", t, {m1_ready, m1_rdata}, exp_m1); end
         n_vec++; if (timeout_err !== err_m) begin n_err++; $display("FAIL rand_err t=%0d: got %b exp %b", t, timeout_err, err_m); end
         err_m = (fin && timed) ? 1'b1 : (timeout_clr ? 1'b0 : err_m);
         if (fin) begin
            last = ow[0];
            v[ow] = 1'b0;
            resume_at[ow] = t + 1 + $urandom_range(1, 3);
         end
         if (winner >= 0) begin
            owner = winner;
            busy_start = t + 1;
            w = $urandom_range(0, 10);
            timed = (w > 7);
            done_at = busy_start + (timed ? 7 : w);
            free_at = done_at + 2;
         end
         next_cyc();
      end
      idle_inputs();
   endtask

   // Test sequence.
   initial begin
      resetn = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_m1_write();
      test_timeout();
      test_timeout_tie();
      test_reset_mid_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
